// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: eight per-cycle modes plus a serializer FSM
// that streams a loaded word out one bit per clock with busy/done status.
module universal_shift_register #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  output logic [WIDTH-1:0] qout,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_SHL  = 3'b010,
    M_SHR  = 3'b011,
    M_ROL  = 3'b100,
    M_ROR  = 3'b101,
    M_ASR  = 3'b110,
    M_CLR  = 3'b111
  } mode_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      qout  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      qout  <= q_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = qout;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          q_nxt     = din;
          cnt_nxt   = CW'(WIDTH - 1);
          state_nxt = SHIFT;
        end else if (en) begin
          case (mode)
            M_HOLD: q_nxt = qout;
            M_LOAD: q_nxt = din;
            M_SHL:  q_nxt = {qout[WIDTH-2:0], sin_r};
            M_SHR:  q_nxt = {sin_l, qout[WIDTH-1:1]};
            M_ROL:  q_nxt = {qout[WIDTH-2:0], qout[WIDTH-1]};
            M_ROR:  q_nxt = {qout[0], qout[WIDTH-1:1]};
            M_ASR:  q_nxt = {qout[WIDTH-1], qout[WIDTH-1:1]};
            M_CLR:  q_nxt = '0;
            default: q_nxt = qout;
          endcase
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          q_nxt   = LSB_FIRST ? {1'b0, qout[WIDTH-1:1]} : {qout[WIDTH-2:0], 1'b0};
          cnt_nxt = cnt - 1'b1;
        end else begin
          // A start on the final bit reloads immediately so words stream with no gap.
          done_nxt = 1'b1;
          if (start) begin
            q_nxt   = din;
            cnt_nxt = CW'(WIDTH - 1);
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state == SHIFT);
  assign ser_out = LSB_FIRST ? qout[0] : qout[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench: MSB-first and LSB-first 8-bit instances plus a
// 2-bit instance, all sharing one set of stimulus inputs.
module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       reset, en, sin_l, sin_r, start;
  logic [2:0] mode;
  logic [7:0] din;

  logic [7:0] q0, q1;
  logic [1:0] q2;
  logic       s0, s1, s2, b0, b1, b2, d0, d1, d2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(8), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din), .sin_l(sin_l),
    .sin_r(sin_r), .start(start), .qout(q0), .ser_out(s0), .busy(b0), .done(d0));

  universal_shift_register #(.WIDTH(8), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din), .sin_l(sin_l),
    .sin_r(sin_r), .start(start), .qout(q1), .ser_out(s1), .busy(b1), .done(d1));

  universal_shift_register #(.WIDTH(2), .LSB_FIRST(1'b0)) dut2 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .din(din[1:0]), .sin_l(sin_l),
    .sin_r(sin_r), .start(start), .qout(q2), .ser_out(s2), .busy(b2), .done(d2));

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; en = 1'b0; mode = 3'b000;
    din = 8'h00; sin_l = 1'b0; sin_r = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({q0, b0, d0} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_init: got q=%h busy=%b done=%b, want 00/0/0", q0, b0, d0);
    end
    din = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({q0, b0} !== {8'hA5, 1'b1}) begin
      errors++;
      $display("[TB] FAIL reset_pre: got q=%h busy=%b, want a5/1", q0, b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({q0, b0, d0} !== {8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_abort: got q=%h busy=%b done=%b, want 00/0/0", q0, b0, d0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (d0 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_nodone[%0d]: got done=%b, want 0", i, d0);
      end
    end
  endtask

  task automatic test_modes();
    logic [2:0] tm [10];
    logic       ten [10];
    logic       tl [10];
    logic       tr [10];
    logic [7:0] texp [10];
    tm   = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b001, 3'b110, 3'b111, 3'b001, 3'b111};
    ten  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tl   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tr   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    texp = '{8'h96, 8'h2D, 8'h16, 8'h2C, 8'h16, 8'h96, 8'hCB, 8'h00, 8'h96, 8'h96};
    do_reset();
    din = 8'h96;
    for (int i = 0; i < 10; i++) begin
      en = ten[i]; mode = tm[i]; sin_l = tl[i]; sin_r = tr[i];
      tick();
      checks++;
      if (q0 !== texp[i]) begin
        errors++;
        $display("[TB] FAIL mode_step%0d(mode=%b en=%b): got %h, want %h", i, tm[i], ten[i], q0, texp[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_serial_msb();
    logic [7:0] word;
    word = 8'hB4;
    do_reset();
    din = word; start = 1'b1;
    tick();
    start = 1'b0; din = 8'hFF; en = 1'b1; mode = 3'b111;
    checks++;
    if (q0 !== 8'hB4) begin
      errors++;
      $display("[TB] FAIL msb_load: got q=%h, want b4", q0);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({b0, s0, d0} !== {1'b1, word[7-k], 1'b0}) begin
        errors++;
        $display("[TB] FAIL msb_bit%0d: got busy=%b ser=%b done=%b, want 1/%b/0", k, b0, s0, d0, word[7-k]);
      end
      tick();
    end
    en = 1'b0;
    checks++;
    if ({b0, d0, q0} !== {1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("[TB] FAIL msb_done: got busy=%b done=%b q=%h, want 0/1/00", b0, d0, q0);
    end
    tick();
    checks++;
    if (d0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL msb_done_pulse: got done=%b, want 0", d0);
    end
  endtask

  task automatic test_serial_lsb();
    logic [7:0] word;
    int         pulses;
    word = 8'hB4;
    pulses = 0;
    do_reset();
    din = word; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({b1, s1} !== {1'b1, word[k]}) begin
        errors++;
        $display("[TB] FAIL lsb_bit%0d: got busy=%b ser=%b, want 1/%b", k, b1, s1, word[k]);
      end
      if (d1 === 1'b1) pulses++;
      tick();
    end
    checks++;
    if ({b1, d1} !== {1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL lsb_done: got busy=%b done=%b, want 0/1", b1, d1);
    end
    for (int k = 0; k < 6; k++) begin
      if (d1 === 1'b1) pulses++;
      tick();
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("[TB] FAIL lsb_done_count: got %0d pulses, want 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] word;
    do_reset();
    din = 8'h01; start = 1'b1;
    tick();
    din = 8'h80;
    for (int k = 0; k < 16; k++) begin
      word = (k < 8) ? 8'h01 : 8'h80;
      checks++;
      if ({b0, s0, d0} !== {1'b1, word[7-(k%8)], (k == 8)}) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d: got busy=%b ser=%b done=%b, want 1/%b/%b",
                 k, b0, s0, d0, word[7-(k%8)], (k == 8));
      end
      if (k == 15) start = 1'b0;
      tick();
    end
    checks++;
    if ({b0, d0} !== {1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL b2b_end: got busy=%b done=%b, want 0/1", b0, d0);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    din = 8'hB4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (b0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_busy4: got busy=%b, want 1", b0);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({b0, q0, d0} !== {1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("[TB] FAIL mid_abort: got busy=%b q=%h done=%b, want 0/00/0", b0, q0, d0);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (d0 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mid_nodone[%0d]: got done=%b, want 0", k, d0);
      end
    end
  endtask

  task automatic test_width2();
    logic [2:0] tm [7];
    logic       tl [7];
    logic       tr [7];
    logic [1:0] texp [7];
    tm   = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    tl   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tr   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    texp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b00};
    do_reset();
    din = 8'h02; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      mode = tm[i]; sin_l = tl[i]; sin_r = tr[i];
      tick();
      checks++;
      if (q2 !== texp[i]) begin
        errors++;
        $display("[TB] FAIL w2_step%0d(mode=%b): got %b, want %b", i, tm[i], q2, texp[i]);
      end
    end
    en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({b2, s2} !== {1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL w2_bit0: got busy=%b ser=%b, want 1/1", b2, s2);
    end
    tick();
    checks++;
    if ({b2, s2} !== {1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL w2_bit1: got busy=%b ser=%b, want 1/0", b2, s2);
    end
    tick();
    checks++;
    if ({b2, d2} !== {1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL w2_done: got busy=%b done=%b, want 0/1", b2, d2);
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_serial_msb();
    test_serial_lsb();
    test_back_to_back();
    test_reset_midstream();
    test_width2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
